load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 43 ++++
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit_align.sv | 56 +++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: datapath width, RISC-V funct3
// encodings, the fixed memory access size, the controller state encoding and
// the request legality check.
package load_store_unit_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // The memory controller is only ever asked for full words.
    localparam logic [2:0] ACCESS_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_e;

    // 1 when a request is illegal (unknown funct3, unsigned store) or
    // misaligned for its access size.
    function automatic logic req_is_bad(input logic       store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = store;
            F3_HU:   bad = store | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle between the pipeline/memory side and the load/store unit.
//   request : req_valid, req_ready, req_store, req_funct3, req_addr, req_wdata
//   response: resp_valid, resp_rdata, resp_err
//   memory  : mem_addr, mem_we, mem_wd, mem_access, mem_rd
// slave  modport: the load/store unit itself.
// master modport: the environment (pipeline and memory controller).
interface load_store_unit_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [WORD_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [WORD_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [WORD_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [WORD_WIDTH-1:0] mem_wd;
    logic [2:0]            mem_access;
    logic [WORD_WIDTH-1:0] mem_rd;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_we, mem_wd, mem_access
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_we, mem_wd, mem_access
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Purely combinational byte-lane logic for the load/store unit.
//   funct3     : access size / signedness
//   offset     : byte offset inside the word (addr[1:0])
//   word       : word returned by memory
//   wdata      : right-aligned store data
//   load_data  : selected lane, sign- or zero-extended
//   store_data : word with the store lane merged in, other bytes preserved
module lsu_align #(
    parameter int WORD_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] load_data,
    output logic [WORD_WIDTH-1:0] store_data
);
    import load_store_unit_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = word[{offset, 3'b000} +: 8];
    assign half_s = word[{offset[1], 4'b0000} +: 16];

    // Extract/extend for loads and lane merge for stores.
    always_comb begin
        load_data  = {WORD_WIDTH{1'b0}};
        store_data = word;
        case (funct3)
            F3_B: begin
                load_data = {{(WORD_WIDTH-8){byte_s[7]}}, byte_s};
                store_data[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                load_data = {{(WORD_WIDTH-16){half_s[15]}}, half_s};
                store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            F3_W: begin
                load_data  = word;
                store_data = wdata;
            end
            F3_BU: begin
                load_data = {{(WORD_WIDTH-8){1'b0}}, byte_s};
            end
            F3_HU: begin
                load_data = {{(WORD_WIDTH-16){1'b0}}, half_s};
            end
            default: begin
                load_data  = {WORD_WIDTH{1'b0}};
                store_data = word;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one pipeline memory request at a time, talks to a
// word-only memory controller and handles sub-word loads (extract/extend) and
// sub-word stores (read-modify-write) itself.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response handshake and memory controller port
// Parameters: WORD_WIDTH (datapath/address width), FAST_SW (aligned SW skips
// the read phase when 1).
module load_store_unit #(
    parameter int WORD_WIDTH = load_store_unit_pkg::WORD_WIDTH,
    parameter bit FAST_SW    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);
    import load_store_unit_pkg::*;

    lsu_state_e            state_r;
    lsu_state_e            next_state_s;
    logic                  store_r;
    logic [2:0]            funct3_r;
    logic [1:0]            addr_lo_r;
    logic [WORD_WIDTH-1:0] wdata_r;
    logic [WORD_WIDTH-1:0] mem_addr_r;
    logic                  mem_we_r;
    logic [WORD_WIDTH-1:0] mem_wd_r;
    logic                  resp_valid_r;
    logic                  resp_err_r;
    logic [WORD_WIDTH-1:0] resp_rdata_r;

    logic                  accept_s;
    logic                  bad_s;
    logic                  fast_sw_s;
    logic [WORD_WIDTH-1:0] load_data_s;
    logic [WORD_WIDTH-1:0] store_data_s;

    assign accept_s  = (state_r == ST_IDLE) && bus.req_valid;
    assign bad_s     = req_is_bad(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
    assign fast_sw_s = (FAST_SW == 1'b1) && bus.req_store && (bus.req_funct3 == F3_W);

    lsu_align #(.WORD_WIDTH(WORD_WIDTH)) u_align (
        .funct3     (funct3_r),
        .offset     (addr_lo_r),
        .word       (bus.mem_rd),
        .wdata      (wdata_r),
        .load_data  (load_data_s),
        .store_data (store_data_s)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    next_state_s = ST_IDLE;
                end else if (bad_s) begin
                    next_state_s = ST_RESP;
                end else if (fast_sw_s) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_READ;
                end
            end
            ST_READ:    next_state_s = ST_CAPTURE;
            ST_CAPTURE: begin
                if (store_r) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            ST_WRITE:   next_state_s = ST_RESP;
            ST_RESP:    next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Request latch and registered outputs. mem_we and resp_valid are set on
    // the edge that enters WRITE/RESP so each lasts exactly that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_r      <= 1'b0;
            funct3_r     <= 3'b000;
            addr_lo_r    <= 2'b00;
            wdata_r      <= {WORD_WIDTH{1'b0}};
            mem_addr_r   <= {WORD_WIDTH{1'b0}};
            mem_we_r     <= 1'b0;
            mem_wd_r     <= {WORD_WIDTH{1'b0}};
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {WORD_WIDTH{1'b0}};
        end else begin
            mem_we_r     <= 1'b0;
            resp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        store_r    <= bus.req_store;
                        funct3_r   <= bus.req_funct3;
                        addr_lo_r  <= bus.req_addr[1:0];
                        wdata_r    <= bus.req_wdata;
                        mem_addr_r <= {bus.req_addr[WORD_WIDTH-1:2], 2'b00};
                        if (bad_s) begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= {WORD_WIDTH{1'b0}};
                        end else if (fast_sw_s) begin
                            mem_we_r <= 1'b1;
                            mem_wd_r <= bus.req_wdata;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (store_r) begin
                        mem_we_r <= 1'b1;
                        mem_wd_r <= store_data_s;
                    end else begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= load_data_s;
                    end
                end
                ST_WRITE: begin
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= {WORD_WIDTH{1'b0}};
                end
                ST_RESP: begin
                    // Leaving for IDLE: address goes back to zero, error flag
                    // only qualifies the pulse just issued.
                    mem_addr_r <= {WORD_WIDTH{1'b0}};
                    resp_err_r <= 1'b0;
                end
                default: begin
                    mem_addr_r <= mem_addr_r;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_wd     = mem_wd_r;
    assign bus.mem_access = ACCESS_WORD;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small synchronous
// word memory model (read data appears one cycle after the address).
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   we_count = 0;
    int   resp_count = 0;
    logic [31:0] last_wd = 32'h0;

    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = 32'h0;
    logic [31:0] pl_data = 32'h0;

    load_store_unit_if #(.WORD_WIDTH(32)) bus ();

    load_store_unit #(.WORD_WIDTH(32), .FAST_SW(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model plus write/response observers.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr[7:2]] <= pl_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wd;
        end
        bus.mem_rd <= mem[bus.mem_addr[7:2]];
        if (bus.mem_we) begin
            we_count <= we_count + 1;
            last_wd  <= bus.mem_wd;
        end
        if (bus.resp_valid) resp_count <= resp_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Present a request for one edge, then scramble the inputs.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        bus.req_store = st; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_store = ~st; bus.req_funct3 = 3'b111;
        bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'h0;
        check("busy_after_accept", {31'h0, bus.req_ready}, 32'h0);
        check("mem_addr_aligned", bus.mem_addr, {a[31:2], 2'b00});
    endtask

    // Cycle count (1 = cycle right after the acceptance edge) of resp_valid.
    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (!bus.resp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.resp_valid) cyc = -1;
    endtask

    task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int exp_cyc,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_we);
        int cyc;
        int we0;
        we0 = we_count;
        issue(st, f3, a, wd);
        wait_resp(cyc);
        check({tag, "_cycle"}, cyc, exp_cyc);
        check({tag, "_rdata"}, bus.resp_rdata, exp_rd);
        check({tag, "_err"}, {31'h0, bus.resp_err}, {31'h0, exp_err});
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'h0, bus.resp_valid}, 32'h0);
        check({tag, "_idle"}, {31'h0, bus.req_ready}, 32'h1);
        check({tag, "_addr0"}, bus.mem_addr, 32'h0);
        check({tag, "_we"}, we_count - we0, exp_we);
    endtask

    initial begin
        int cyc;
        int we0;
        int rc0;
        logic [31:0] exp3 [0:2];
        logic [31:0] adr3 [0:2];

        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        preload(32'h10, 32'h8899_AABB);
        preload(32'h14, 32'h5566_7788);
        preload(32'h20, 32'h1122_3344);
        preload(32'h30, 32'hCAFE_F00D);

        // Reset values.
        check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("rst_mem_wd", bus.mem_wd, 32'h0);
        check("mem_access", {29'h0, bus.mem_access}, 32'h2);
        rst_n = 1'b1;

        // Loads (first one accepted on the first edge after reset release).
        txn("lb_12",  1'b0, 3'b000, 32'h12, 32'h0, 3, 32'hFFFF_FF99, 1'b0, 0);
        txn("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 3, 32'h0000_8899, 1'b0, 0);
        txn("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 3, 32'h8899_AABB, 1'b0, 0);
        txn("lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 3, 32'hFFFF_AABB, 1'b0, 0);
        txn("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 3, 32'h0000_0088, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1 check("rdata_hold", bus.resp_rdata, 32'h0000_0088);

        // Read-modify-write byte store, then read back.
        txn("sb_21",  1'b1, 3'b000, 32'h21, 32'hDEAD_BEEF, 4, 32'h0, 1'b0, 1);
        check("sb_21_wd", last_wd, 32'h1122_EF44);
        txn("lw_20a", 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'h1122_EF44, 1'b0, 0);
        txn("sh_22",  1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 4, 32'h0, 1'b0, 1);
        txn("lw_20b", 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'hBEEF_EF44, 1'b0, 0);

        // Fast aligned word store.
        txn("sw_14",  1'b1, 3'b010, 32'h14, 32'hA5A5_5A5A, 2, 32'h0, 1'b0, 1);
        check("sw_14_wd", last_wd, 32'hA5A5_5A5A);

        // Misaligned / illegal requests.
        txn("sw_22_mis",  1'b1, 3'b010, 32'h22, 32'h1234_5678, 1, 32'h0, 1'b1, 0);
        txn("ld_f3_011",  1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0);
        txn("sbu_illegal", 1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0);
        txn("lh_11_mis",  1'b0, 3'b001, 32'h11, 32'h0, 1, 32'h0, 1'b1, 0);

        // Reset during CAPTURE of a halfword store.
        we0 = we_count;
        rc0 = resp_count;
        issue(1'b1, 3'b001, 32'h30, 32'h0000_1234);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, bus.req_ready}, 32'h1);
        check("abort_mem_addr", bus.mem_addr, 32'h0);
        check("abort_mem_we", {31'h0, bus.mem_we}, 32'h0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_we", we_count - we0, 0);
        check("abort_no_resp", resp_count - rc0, 0);
        check("abort_mem30", mem[12], 32'hCAFE_F00D);
        txn("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 0);

        // Back-to-back word loads with req_valid held high.
        adr3[0] = 32'h10; exp3[0] = 32'h8899_AABB;
        adr3[1] = 32'h20; exp3[1] = 32'hBEEF_EF44;
        adr3[2] = 32'h14; exp3[2] = 32'hA5A5_5A5A;
        rc0 = resp_count;
        bus.req_store = 1'b0; bus.req_funct3 = 3'b010; bus.req_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            int n;
            bus.req_addr = adr3[i];
            bus.req_valid = 1'b1;
            n = 0;
            while (!bus.req_ready && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check("b2b_ready_wait", {31'h0, bus.req_ready}, 32'h1);
            @(posedge clk); #1;
            check("b2b_busy", {31'h0, bus.req_ready}, 32'h0);
            check("b2b_addr", bus.mem_addr, adr3[i]);
            wait_resp(cyc);
            check("b2b_cycle", cyc, 3);
            check("b2b_rdata", bus.resp_rdata, exp3[i]);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_resp_count", resp_count - rc0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
